// File: rtl/powlib_ipbytesrl_if.sv
// Handshake bundle for powlib_ipbytesrl: packed intr0 word in, enabled bytes out.
// POWLIB_OPW sets the op field width and defaults to 2 when not supplied.
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif

interface powlib_ipbytesrl_if #(
    parameter int B_BPD = 4
);
    localparam int B_DW = 8 * B_BPD;
    localparam int OPW  = `POWLIB_OPW;
    localparam int B_WW = B_DW + B_BPD + OPW;
    localparam int IW   = (B_BPD > 1) ? $clog2(B_BPD) : 1;

    logic [B_WW-1:0] wrdata;
    logic            wrvld;
    logic            wrrdy;
    logic [7:0]      rddata;
    logic [OPW-1:0]  rdop;
    logic [IW-1:0]   rdidx;
    logic            rdlast;
    logic            rdvld;
    logic            rdrdy;
    logic            busy;

    modport slave (
        input  wrdata, wrvld, rdrdy,
        output wrrdy, rddata, rdop, rdidx, rdlast, rdvld, busy
    );

    modport master (
        output wrdata, wrvld, rdrdy,
        input  wrrdy, rddata, rdop, rdidx, rdlast, rdvld, busy
    );
endinterface

// File: rtl/powlib_ipbytesrl.sv
// Serialises a packed intr0 word into its enabled bytes, lowest lane first.
// Define POWLIB_IPBYTESRL_BYPASS_EN to accept the next word alongside the last byte.
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif

module powlib_ipbytesrl #(
    parameter int B_BPD = 4
) (
    input logic                clk,
    input logic                rst,
    powlib_ipbytesrl_if.slave  bus
);
    localparam int B_DW = 8 * B_BPD;
    localparam int OPW  = `POWLIB_OPW;
    localparam int IW   = (B_BPD > 1) ? $clog2(B_BPD) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [B_DW-1:0]  data_q;
    logic [OPW-1:0]   op_q;
    logic [B_BPD-1:0] mask_q;

    logic [B_DW-1:0]  in_data;
    logic [B_BPD-1:0] in_be;
    logic [OPW-1:0]   in_op;
    logic             wr_rdy;
    logic             wr_xfer;
    logic             rd_xfer;
    logic [B_BPD-1:0] rem_mask;

    logic [B_DW-1:0]  src_data;
    logic [B_BPD-1:0] src_mask;
    logic [OPW-1:0]   src_op;
    logic [IW-1:0]    ld_idx;
    logic [7:0]       ld_byte;
    logic             ld_last;

    assign in_data  = bus.wrdata[B_DW-1:0];
    assign in_be    = bus.wrdata[B_DW +: B_BPD];
    assign in_op    = bus.wrdata[B_DW+B_BPD +: OPW];
    assign wr_xfer  = bus.wrvld & wr_rdy;
    assign rd_xfer  = bus.rdvld & bus.rdrdy;
    assign rem_mask = mask_q & ~(B_BPD'(1) << bus.rdidx);
    assign bus.wrrdy = wr_rdy;
    assign bus.busy  = (state == SHIFT);

    always_comb begin
        wr_rdy = 1'b0;
        if (rst) begin
            if (state == IDLE) begin
                wr_rdy = 1'b1;
            end
`ifdef POWLIB_IPBYTESRL_BYPASS_EN
            else begin
                wr_rdy = bus.rdvld & bus.rdlast & bus.rdrdy;
            end
`endif
        end
    end

    // Next byte comes from the held word mid-word, otherwise from the incoming word.
    always_comb begin
        src_data = in_data;
        src_mask = in_be;
        src_op   = in_op;
        if (state == SHIFT && !bus.rdlast) begin
            src_data = data_q;
            src_mask = rem_mask;
            src_op   = op_q;
        end
        ld_idx = '0;
        for (int i = B_BPD - 1; i >= 0; i--) begin
            if (src_mask[i]) begin
                ld_idx = IW'(i);
            end
        end
        ld_byte = '0;
        for (int i = 0; i < B_BPD; i++) begin
            if (ld_idx == IW'(i)) begin
                ld_byte = src_data[8*i +: 8];
            end
        end
        ld_last = ((src_mask & (src_mask - B_BPD'(1))) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_q     <= '0;
            op_q       <= '0;
            mask_q     <= '0;
            bus.rddata <= '0;
            bus.rdop   <= '0;
            bus.rdidx  <= '0;
            bus.rdlast <= 1'b0;
            bus.rdvld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_xfer && in_be != '0) begin
                        data_q     <= in_data;
                        op_q       <= in_op;
                        mask_q     <= in_be;
                        bus.rddata <= ld_byte;
                        bus.rdidx  <= ld_idx;
                        bus.rdop   <= src_op;
                        bus.rdlast <= ld_last;
                        bus.rdvld  <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rd_xfer) begin
                        if (!bus.rdlast) begin
                            mask_q     <= rem_mask;
                            bus.rddata <= ld_byte;
                            bus.rdidx  <= ld_idx;
                            bus.rdop   <= src_op;
                            bus.rdlast <= ld_last;
                        end
`ifdef POWLIB_IPBYTESRL_BYPASS_EN
                        else if (wr_xfer && in_be != '0) begin
                            data_q     <= in_data;
                            op_q       <= in_op;
                            mask_q     <= in_be;
                            bus.rddata <= ld_byte;
                            bus.rdidx  <= ld_idx;
                            bus.rdop   <= src_op;
                            bus.rdlast <= ld_last;
                        end
`endif
                        else begin
                            bus.rdvld  <= 1'b0;
                            bus.rdlast <= 1'b0;
                            mask_q     <= '0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_powlib_ipbytesrl.sv
// Directed bench for powlib_ipbytesrl: a byte-queue model checked every cycle plus literal checks.
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif

module tb_powlib_ipbytesrl;
    localparam int B_BPD = 4;
`ifdef POWLIB_IPBYTESRL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] op;
        logic [1:0] idx;
        logic       lst;
    } byte_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    byte_t q[$];
    byte_t got[$];
    int    tcap[$];
    bit    m_acc;
    bit    m_pop;

    always #5 clk = ~clk;

    powlib_ipbytesrl_if #(.B_BPD(B_BPD)) bus ();

    powlib_ipbytesrl #(.B_BPD(B_BPD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // The DUT may take a word when it holds no pending bytes, or in bypass when its last byte leaves now.
    function automatic bit model_wrrdy();
        return rst && (q.size() == 0 || (BYPASS && q.size() == 1 && bus.rdrdy));
    endfunction

    function automatic void push_word(input logic [37:0] w);
        logic [31:0] d;
        logic [3:0]  be;
        int          hi;
        d  = w[31:0];
        be = w[35:32];
        hi = -1;
        for (int i = 0; i < B_BPD; i++) if (be[i]) hi = i;
        for (int i = 0; i < B_BPD; i++) begin
            if (be[i]) q.push_back('{d: d[8*i +: 8], op: w[37:36], idx: i[1:0], lst: (i == hi)});
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else begin
            m_acc = bus.wrvld && model_wrrdy();
            m_pop = (q.size() > 0) && bus.rdrdy;
            if (m_pop) void'(q.pop_front());
            if (m_acc) push_word(bus.wrdata);
        end
    end

    always @(negedge clk) begin
        chk("rdvld", bus.rdvld, q.size() > 0);
        chk("busy", bus.busy, q.size() > 0);
        chk("wrrdy", bus.wrrdy, model_wrrdy());
        if (q.size() > 0) begin
            chk("rddata", bus.rddata, q[0].d);
            chk("rdop", bus.rdop, q[0].op);
            chk("rdidx", bus.rdidx, q[0].idx);
            chk("rdlast", bus.rdlast, q[0].lst);
        end else begin
            chk("rdlast_idle", bus.rdlast, 1'b0);
        end
        if (bus.rdvld && bus.rdrdy) begin
            got.push_back('{d: bus.rddata, op: bus.rdop, idx: bus.rdidx, lst: bus.rdlast});
            tcap.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] be, input logic [1:0] op);
        bit a;
        bit accepted;
        accepted = 1'b0;
        bus.wrdata = {op, be, d};
        bus.wrvld  = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            #1;
            a = bus.wrrdy;
            step();
            if (a) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
        end
        bus.wrvld = 1'b0;
        chk("accept", accepted, 1'b1);
    endtask

    task automatic check_output(input string name, input int n, input logic [3:0][7:0] eb,
                                input logic [3:0][1:0] ei, input logic [3:0] el, input logic [3:0][1:0] eo);
        for (int i = 0; i < 100 && got.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        chk({name, "_count"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++) begin
            chk({name, "_byte"}, got[k].d, eb[k]);
            chk({name, "_idx"}, got[k].idx, ei[k]);
            chk({name, "_last"}, got[k].lst, el[k]);
            chk({name, "_op"}, got[k].op, eo[k]);
        end
    endtask

    initial begin
        int lows;
        int n;
        bit a;
        bus.wrdata = '0;
        bus.wrvld  = 1'b0;
        bus.rdrdy  = 1'b1;
        #12;
        chk("reset_rdvld", bus.rdvld, 1'b0);
        chk("reset_rdlast", bus.rdlast, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_rddata", bus.rddata, 8'h00);
        chk("reset_rdop", bus.rdop, 2'd0);
        chk("reset_rdidx", bus.rdidx, 2'd0);
        chk("reset_wrrdy", bus.wrrdy, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        step();

        $display("[TB] full word");
        got.delete(); tcap.delete();
        apply_stimulus(32'hDDCCBBAA, 4'b1111, 2'd1);
        check_output("full", 4, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, {2'd3, 2'd2, 2'd1, 2'd0},
                     4'b1000, {2'd1, 2'd1, 2'd1, 2'd1});
        if (tcap.size() >= 4) begin
            chk("first_byte_latency", tcap[0] - acc_cyc, 0);
            chk("full_span", tcap[3] - tcap[0], 3);
        end

        $display("[TB] sparse enables");
        step();
        got.delete(); tcap.delete();
        apply_stimulus(32'h44332211, 4'b1010, 2'd2);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.wrrdy) break;
            lows++;
        end
        chk("sparse_wrrdy_low", lows, BYPASS ? 1 : 2);
        check_output("sparse", 2, {8'h00, 8'h00, 8'h44, 8'h22}, {2'd0, 2'd0, 2'd3, 2'd1},
                     4'b0010, {2'd0, 2'd0, 2'd2, 2'd2});
        if (tcap.size() >= 2) chk("sparse_skip", tcap[1] - tcap[0], 1);

        $display("[TB] backpressure");
        step();
        got.delete(); tcap.delete();
        bus.rdrdy = 1'b0;
        apply_stimulus(32'h00332211, 4'b0111, 2'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_rddata", bus.rddata, 8'h11);
            chk("stall_rdidx", bus.rdidx, 2'd0);
            chk("stall_rdvld", bus.rdvld, 1'b1);
        end
        step();
        bus.rdrdy = 1'b1;
        check_output("bp", 3, {8'h00, 8'h33, 8'h22, 8'h11}, {2'd0, 2'd2, 2'd1, 2'd0},
                     4'b0100, {2'd0, 2'd3, 2'd3, 2'd3});

        $display("[TB] zero enable");
        step();
        got.delete(); tcap.delete();
        apply_stimulus(32'h12345678, 4'b0000, 2'd1);
        @(negedge clk);
        #1;
        chk("zero_rdvld", bus.rdvld, 1'b0);
        chk("zero_busy", bus.busy, 1'b0);
        apply_stimulus(32'h000000EE, 4'b0001, 2'd0);
        check_output("zero", 1, {8'h00, 8'h00, 8'h00, 8'hEE}, {2'd0, 2'd0, 2'd0, 2'd0},
                     4'b0001, {2'd0, 2'd0, 2'd0, 2'd0});

        $display("[TB] reset mid-word");
        step();
        got.delete(); tcap.delete();
        apply_stimulus(32'hDDCCBBAA, 4'b1111, 2'd1);
        for (int i = 0; i < 50 && got.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        chk("pre_reset_count", got.size(), 2);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_rdvld", bus.rdvld, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_wrrdy", bus.wrrdy, 1'b0);
        chk("midrst_rddata", bus.rddata, 8'h00);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("post_reset_wrrdy", bus.wrrdy, 1'b1);
        got.delete(); tcap.delete();
        apply_stimulus(32'h04030201, 4'b1111, 2'd2);
        check_output("after_rst", 4, {8'h04, 8'h03, 8'h02, 8'h01}, {2'd3, 2'd2, 2'd1, 2'd0},
                     4'b1000, {2'd2, 2'd2, 2'd2, 2'd2});

        $display("[TB] back-to-back");
        step();
        got.delete(); tcap.delete();
        bus.wrdata = {2'd1, 4'b0011, 32'h0000BBAA};
        bus.wrvld  = 1'b1;
        n = 0;
        for (int i = 0; i < 50 && n < 2; i++) begin
            @(negedge clk);
            #1;
            a = bus.wrrdy;
            step();
            if (a) begin
                n++;
                bus.wrdata = {2'd2, 4'b0011, 32'h0000DDCC};
            end
        end
        bus.wrvld = 1'b0;
        chk("b2b_accepts", n, 2);
        check_output("b2b", 4, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, {2'd1, 2'd0, 2'd1, 2'd0},
                     4'b1010, {2'd2, 2'd2, 2'd1, 2'd1});
        if (tcap.size() >= 4) chk("b2b_span", tcap[3] - tcap[0], BYPASS ? 3 : 4);

        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
